note_sequencer: RTL
===================

# note_sequencer

Playback engine that consumes the 2-bit play mode from the play-state controller (00 normal, 01 double time, 10 reverse) and walks a song's note ROM. On each note boundary it fetches the next entry forward or backward, times its duration against an external beat strobe at 1× or 2× rate, and presents note/duration with a one-cycle `new_note` strobe to the note player. It sits between the play-state controller and the note player, driving the song ROM address.

## Interface
- `ADDR_W`, 5: note-index width per song; a song holds 2^ADDR_W entries.
- `NOTE_W`, 6: note code width.
- `DUR_W`, 6: duration width, in beats.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `play` input 1: 1 = run, 0 = pause; freezes the duration counter and FSM.
- `play_state` input 2: 00 normal, 01 double time, 10 reverse; 11 treated as 00.
- `song` input 2: song select.
- `beat` input 1: one-cycle beat strobe; consecutive strobes are at least 4 cycles apart.
- `rom_addr` output ADDR_W+2: {song latch, note index}.
- `rom_data` input NOTE_W+DUR_W: {note, duration}, valid 1 cycle after `rom_addr`.
- `note` output NOTE_W: current note.
- `duration` output DUR_W: current note's ROM duration.
- `new_note` output 1: one-cycle strobe when `note`/`duration` update.
- `song_done` output 1: level, high while in DONE.

## Operation
- Reset values:
  - FSM = FETCH, index = 0, song latch = `song`, remaining = 0.
  - `note` = 0, `duration` = 0, `new_note` = 0, `song_done` = 0.
- States:
  - FETCH → WAIT (1 cycle) → LOAD → PLAY.
  - PLAY → FETCH on note end.
  - PLAY → DONE at song end.
- LOAD:
  - Captures `rom_data`; `note`, `duration`, and remaining ← ROM fields.
  - Raises `new_note` the following cycle.
  - If the ROM duration is 0, the entry is an end marker: go to DONE instead, with `new_note` not raised.
- PLAY, on `beat` with `play` = 1:
  - Normal: remaining −1.
  - Double time: remaining −2, saturating at 0.
- Note end: remaining reaches 0.
  - Forward (00/01/11): index +1. If index was 2^ADDR_W−1, go to DONE.
  - Reverse (10): index −1. If index was 0, go to DONE.
  - Otherwise go to FETCH.
- Direction is sampled only at note end. A mode change mid-note affects only the rate, from the next beat.
- `beat` is ignored in FETCH, WAIT, LOAD and DONE, and whenever `play` = 0.
- Song change: `song` ≠ song latch in any state → latch `song`, index ← 0, state ← FETCH next cycle. This aborts any in-flight fetch; `song_done` drops.
- DONE holds until a song change or reset.
- Width rules: index arithmetic is modulo 2^ADDR_W, with the end checks made before the wrap. remaining never underflows.

## Timing
- Beat in cycle N that zeroes remaining:
  - N+1: FETCH, new `rom_addr` valid.
  - N+2: WAIT, ROM data valid.
  - N+3: LOAD→PLAY edge; `note`/`duration` valid and `new_note` = 1 for exactly cycle N+3.
- After reset release: first `new_note` in cycle 3.
- `rom_addr` is combinational from the index and song latch registers.
- Reset asserted mid-note: all outputs return to reset values immediately (asynchronous). Playback restarts at index 0 after release.

## Configuration
- `NOTE_SEQ_LOOP_EN`
  - Defined: song end wraps instead of entering DONE. Forward past the last index, or a zero-duration marker, goes to index 0 and FETCH. Reverse past index 0 goes to index 2^ADDR_W−1 and FETCH. `song_done` is tied 0.
  - Undefined: behaviour as in Operation.

## Test plan
- Reset, ROM entry 0 = {note 12, dur 4}, entry 1 = {note 20, dur 2}, normal mode, beat every 8 cycles → `new_note` in cycle 3 with note 12; second `new_note` with note 20, 3 cycles after the 4th beat.
- Double time, entry dur 5, beats → note ends on the 3rd beat (5→3→1→0, saturating).
- At index 3, switch to reverse mid-note → rate unchanged for that note; next fetch at index 2; continuing, DONE after index 0 ends, with `song_done` = 1.
- Forward play into an entry with dur 0 at index 6 → DONE, `new_note` not raised, `song_done` = 1. With `NOTE_SEQ_LOOP_EN` defined, next `rom_addr` index = 0.
- `play` = 0 for 20 cycles spanning 2 beats → remaining unchanged; resumes counting on the first beat after `play` = 1.
- Change `song` 1→2 during WAIT → `rom_addr` = {2, 0} next cycle; the stale ROM data is never presented on `note`.

Source files
------------

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer
// Purpose  : Song playback engine. Walks a song's note ROM forward or
//            backward, times each note's duration against an external beat
//            strobe (1x or 2x rate), and presents note/duration with a
//            one-cycle new_note strobe to the note player.
//
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            play           - 1 = run, 0 = pause (freezes FSM and counter)
//            play_state[1:0]- 00 normal, 01 double time, 10 reverse, 11 = 00
//            song[1:0]      - song select; a change restarts at index 0
//            beat           - one-cycle beat strobe
//            rom_addr       - {song latch, note index}, combinational
//            rom_data       - {note, duration}, valid 1 cycle after rom_addr
//            note, duration - current note and its ROM duration
//            new_note       - one-cycle strobe when note/duration update
//            song_done      - high while the song has ended
//
// Config   : NOTE_SEQ_LOOP_EN - when defined, song end wraps around instead
//            of entering DONE, and song_done is tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module note_sequencer #(
  parameter int ADDR_W = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     play,
  input  logic [1:0]               play_state,
  input  logic [1:0]               song,
  input  logic                     beat,
  output logic [ADDR_W+1:0]        rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]  rom_data,
  output logic [NOTE_W-1:0]        note,
  output logic [DUR_W-1:0]         duration,
  output logic                     new_note,
  output logic                     song_done
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   index, index_nxt;
  logic [DUR_W-1:0]    remaining, remaining_nxt;
  logic [1:0]          song_q;
  logic                song_valid;
  logic                capture;

  logic [1:0]          song_eff;
  logic                song_chg;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic [DUR_W-1:0]    dec_step;
  logic [DUR_W-1:0]    rem_dec;
  logic                reverse;

  // The song latch takes the live song input until the first clock after
  // reset, so reset behaves as if the latch were loaded from song without
  // needing an asynchronous data load.
  assign song_eff = song_valid ? song_q : song;
  assign song_chg = song_valid && (song != song_q);
  assign rom_addr = {song_eff, index};

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  // Rate follows the live mode on every beat; direction only matters at note end.
  assign dec_step = (play_state == 2'b01) ? DUR_W'(2) : DUR_W'(1);
  assign rem_dec  = (remaining > dec_step) ? (remaining - dec_step) : '0;
  assign reverse  = (play_state == 2'b10);

`ifdef NOTE_SEQ_LOOP_EN
  assign song_done = 1'b0;
`else
  assign song_done = (state == S_DONE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    index_nxt     = index;
    remaining_nxt = remaining;
    capture       = 1'b0;

    if (song_chg) begin
      // A song change overrides everything, including an in-flight fetch.
      state_nxt = S_FETCH;
      index_nxt = '0;
    end else if (play) begin
      case (state)
        S_FETCH: state_nxt = S_WAIT;

        // ROM data for the current index is valid here; it is latched on the
        // way into LOAD so new_note is high during the LOAD cycle itself.
        S_WAIT: begin
          if (rom_dur == '0) begin
`ifdef NOTE_SEQ_LOOP_EN
            index_nxt = '0;
            state_nxt = S_FETCH;
`else
            state_nxt = S_DONE;
`endif
          end else begin
            capture       = 1'b1;
            remaining_nxt = rom_dur;
            state_nxt     = S_LOAD;
          end
        end

        S_LOAD: state_nxt = S_PLAY;

        S_PLAY: begin
          if (beat) begin
            remaining_nxt = rem_dec;
            if (rem_dec == '0) begin
              // Index wraps modulo 2^ADDR_W; the end test uses the old index.
              if (reverse) begin
                index_nxt = index - ADDR_W'(1);
              end else begin
                index_nxt = index + ADDR_W'(1);
              end
`ifdef NOTE_SEQ_LOOP_EN
              state_nxt = S_FETCH;
`else
              if (reverse ? (index == '0) : (&index)) begin
                state_nxt = S_DONE;
              end else begin
                state_nxt = S_FETCH;
              end
`endif
            end
          end
        end

        S_DONE: state_nxt = S_DONE;

        default: state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index      <= '0;
      remaining  <= '0;
      song_q     <= '0;
      song_valid <= 1'b0;
      note       <= '0;
      duration   <= '0;
      new_note   <= 1'b0;
    end else begin
      index      <= index_nxt;
      remaining  <= remaining_nxt;
      song_valid <= 1'b1;
      new_note   <= capture;
      if (!song_valid || song_chg) begin
        song_q <= song;
      end
      if (capture) begin
        note     <= rom_note;
        duration <= rom_dur;
      end
    end
  end

endmodule
`default_nettype wire
